sc_fifo: RTL and testbench

Single-clock, parametrised FIFO that succeeds the dual-pointer r_fifo for datapath buffering inside one clock domain, e.g. between the sample packer and the host-interface framer. It adds full-DEPTH usable capacity, an occupancy count, programmable almost-full and almost-empty thresholds, and sticky overflow/underflow error flags. It also adds a synchronous flush and a selectable output mode: first-word-fall-through or registered read.

---
 rtl/sc_fifo_if.sv | 29 ++
 rtl/sc_fifo.sv | 101 ++++++++++
 tb/tb_sc_fifo.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/sc_fifo_if.sv
// Handshake/data bundle for sc_fifo: the producer/consumer side is the master,
// and the FIFO is the slave.
interface sc_fifo_if #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_BITS = 9
);
  logic                  CLEAR;
  logic [WIDTH-1:0]      DATA;
  logic                  WE;
  logic                  RE;
  logic [WIDTH-1:0]      Q;
  logic                  FULL;
  logic                  EMPTY;
  logic                  AFULL;
  logic                  AEMPTY;
  logic [DEPTH_BITS:0]   COUNT;
  logic                  OVERFLOW;
  logic                  UNDERFLOW;

  modport master (
    output CLEAR, DATA, WE, RE,
    input  Q, FULL, EMPTY, AFULL, AEMPTY, COUNT, OVERFLOW, UNDERFLOW
  );

  modport slave (
    input  CLEAR, DATA, WE, RE,
    output Q, FULL, EMPTY, AFULL, AEMPTY, COUNT, OVERFLOW, UNDERFLOW
  );
endinterface

// File: rtl/sc_fifo.sv
// Single-clock FIFO with occupancy count, programmable almost-full/empty levels,
// sticky error flags, synchronous flush, and an FWFT or registered-read output.
module sc_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 512,
  parameter int DEPTH_BITS = 9,
  parameter int AFULL_LVL  = 508,
  parameter int AEMPTY_LVL = 4,
  parameter int FWFT       = 1
) (
  input  logic     CLOCK,
  input  logic     RESET,
  sc_fifo_if.slave bus
);
  localparam logic [DEPTH_BITS:0] DEPTH_C  = (DEPTH_BITS+1)'(DEPTH);
  localparam logic [DEPTH_BITS:0] AFULL_C  = (DEPTH_BITS+1)'(AFULL_LVL);
  localparam logic [DEPTH_BITS:0] AEMPTY_C = (DEPTH_BITS+1)'(AEMPTY_LVL);

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_BITS-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [DEPTH_BITS:0]   count_q, count_d;
  logic                  ovf_q, ovf_d, udf_q, udf_d;
  logic                  full, empty, rd, wr;

  // Full and empty come only from the count; the pointers are equal in both.
  assign full  = (count_q == DEPTH_C);
  assign empty = (count_q == '0);
  assign rd    = bus.RE & ~empty;
  assign wr    = bus.WE & (~full | rd);

  always_comb begin
    wp_d    = wp_q;
    rp_d    = rp_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    udf_d   = udf_q;
    if (bus.CLEAR) begin
      wp_d    = '0;
      rp_d    = '0;
      count_d = '0;
      ovf_d   = 1'b0;
      udf_d   = 1'b0;
    end else begin
      if (wr) wp_d = wp_q + DEPTH_BITS'(1);
      if (rd) rp_d = rp_q + DEPTH_BITS'(1);
      count_d = count_q + (DEPTH_BITS+1)'(wr) - (DEPTH_BITS+1)'(rd);
      if (bus.WE & ~wr) ovf_d = 1'b1;
      if (bus.RE & ~rd) udf_d = 1'b1;
    end
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  // Storage is deliberately left out of reset so it can map onto RAM.
  always_ff @(posedge CLOCK) begin
    if (wr && !bus.CLEAR) mem[wp_q] <= bus.DATA;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign bus.Q = empty ? '0 : mem[rp_q];
    end else begin : g_reg
      logic [WIDTH-1:0] q_q, q_d;

      always_comb begin
        q_d = q_q;
        if (bus.CLEAR)  q_d = '0;
        else if (rd)    q_d = mem[rp_q];
      end

      always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) q_q <= '0;
        else        q_q <= q_d;
      end

      assign bus.Q = q_q;
    end
  endgenerate

  assign bus.FULL      = full;
  assign bus.EMPTY     = empty;
  assign bus.AFULL     = (count_q >= AFULL_C);
  assign bus.AEMPTY    = (count_q <= AEMPTY_C);
  assign bus.COUNT     = count_q;
  assign bus.OVERFLOW  = ovf_q;
  assign bus.UNDERFLOW = udf_q;
endmodule

// File: tb/tb_sc_fifo.sv
// Bench for sc_fifo: one FWFT and one registered-read instance share stimulus and
// are compared every cycle against a queue-based reference, plus fixed expectations.
module tb_sc_fifo;
  localparam int W  = 8;
  localparam int D  = 8;
  localparam int DB = 3;
  localparam int AF = 6;
  localparam int AE = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         clr = 1'b0;
  logic         we = 1'b0;
  logic         re = 1'b0;
  logic [W-1:0] din = '0;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  sc_fifo_if #(.WIDTH(W), .DEPTH_BITS(DB)) if0 ();
  sc_fifo_if #(.WIDTH(W), .DEPTH_BITS(DB)) if1 ();

  assign if0.CLEAR = clr;
  assign if0.DATA  = din;
  assign if0.WE    = we;
  assign if0.RE    = re;
  assign if1.CLEAR = clr;
  assign if1.DATA  = din;
  assign if1.WE    = we;
  assign if1.RE    = re;

  sc_fifo #(.WIDTH(W), .DEPTH(D), .DEPTH_BITS(DB), .AFULL_LVL(AF), .AEMPTY_LVL(AE), .FWFT(1))
    dut0 (.CLOCK(clk), .RESET(rst_n), .bus(if0.slave));
  sc_fifo #(.WIDTH(W), .DEPTH(D), .DEPTH_BITS(DB), .AFULL_LVL(AF), .AEMPTY_LVL(AE), .FWFT(0))
    dut1 (.CLOCK(clk), .RESET(rst_n), .bus(if1.slave));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a queue holding the stored words, two sticky bits and the last word read.
  logic [W-1:0] mq[$];
  logic         m_ovf = 1'b0;
  logic         m_udf = 1'b0;
  logic [W-1:0] m_qreg = '0;
  logic         m_rd, m_wr;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || clr) begin
      mq.delete();
      m_ovf  = 1'b0;
      m_udf  = 1'b0;
      m_qreg = '0;
    end else begin
      m_rd = re && (mq.size() > 0);
      m_wr = we && (mq.size() < D || m_rd);
      if (we && !m_wr) m_ovf = 1'b1;
      if (re && !m_rd) m_udf = 1'b1;
      if (m_rd) m_qreg = mq.pop_front();
      if (m_wr) mq.push_back(din);
    end
  end

  always @(negedge clk) begin
    int sz;
    sz = mq.size();
    chk("count0", 32'(if0.COUNT), 32'(sz));
    chk("count1", 32'(if1.COUNT), 32'(sz));
    chk("full0",  32'(if0.FULL),  32'(sz == D));
    chk("empty0", 32'(if0.EMPTY), 32'(sz == 0));
    chk("empty1", 32'(if1.EMPTY), 32'(sz == 0));
    chk("afull0", 32'(if0.AFULL), 32'(sz >= AF));
    chk("aempty0", 32'(if0.AEMPTY), 32'(sz <= AE));
    chk("ovf0",   32'(if0.OVERFLOW),  32'(m_ovf));
    chk("udf0",   32'(if0.UNDERFLOW), 32'(m_udf));
    chk("ovf1",   32'(if1.OVERFLOW),  32'(m_ovf));
    chk("udf1",   32'(if1.UNDERFLOW), 32'(m_udf));
    chk("q_fwft", 32'(if0.Q), (sz > 0) ? 32'(mq[0]) : 32'd0);
    chk("q_reg",  32'(if1.Q), 32'(m_qreg));
  end

  task automatic cyc(input logic w, input logic r, input logic [W-1:0] d, input logic c);
    we = w; re = r; din = d; clr = c;
    @(posedge clk);
    #1;
    we = 1'b0; re = 1'b0; clr = 1'b0;
  endtask

  initial begin
    logic [W-1:0] exp_rd [8];
    exp_rd[0] = 8'h02; exp_rd[1] = 8'h03; exp_rd[2] = 8'h04; exp_rd[3] = 8'h05;
    exp_rd[4] = 8'h06; exp_rd[5] = 8'h07; exp_rd[6] = 8'h08; exp_rd[7] = 8'hAA;

    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", 32'(if0.COUNT), 0);
    chk("rst_empty", 32'(if0.EMPTY), 1);
    chk("rst_aempty", 32'(if0.AEMPTY), 1);
    chk("rst_full", 32'(if0.FULL), 0);
    chk("rst_afull", 32'(if0.AFULL), 0);
    chk("rst_q0", 32'(if0.Q), 0);
    chk("rst_q1", 32'(if1.Q), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Fill 1..8.
    for (int i = 1; i <= 8; i++) cyc(1'b1, 1'b0, W'(i), 1'b0);
    chk("fill_full", 32'(if0.FULL), 1);
    chk("fill_count", 32'(if0.COUNT), 8);
    chk("fill_afull", 32'(if0.AFULL), 1);

    // Paired write+read while full.
    cyc(1'b1, 1'b1, 8'hAA, 1'b0);
    chk("pair_count", 32'(if0.COUNT), 8);
    chk("pair_ovf", 32'(if0.OVERFLOW), 0);
    chk("pair_qreg", 32'(if1.Q), 8'h01);

    // Rejected write.
    cyc(1'b1, 1'b0, 8'h33, 1'b0);
    chk("ovf_set", 32'(if0.OVERFLOW), 1);

    // Drain.
    for (int i = 0; i < 8; i++) begin
      chk("drain_q0", 32'(if0.Q), 32'(exp_rd[i]));
      cyc(1'b0, 1'b1, 8'h00, 1'b0);
      chk("drain_q1", 32'(if1.Q), 32'(exp_rd[i]));
    end
    chk("drain_empty", 32'(if0.EMPTY), 1);
    chk("drain_aempty", 32'(if0.AEMPTY), 1);
    chk("drain_qz", 32'(if0.Q), 0);
    chk("ovf_sticky", 32'(if0.OVERFLOW), 1);

    // Write+read while empty.
    cyc(1'b1, 1'b1, 8'h77, 1'b0);
    chk("emp_count", 32'(if0.COUNT), 1);
    chk("emp_udf", 32'(if0.UNDERFLOW), 1);

    // Flush ignores WE/RE in the same cycle.
    cyc(1'b1, 1'b1, 8'h11, 1'b1);
    chk("clr_ovf", 32'(if0.OVERFLOW), 0);
    chk("clr_udf", 32'(if0.UNDERFLOW), 0);
    chk("clr_count", 32'(if0.COUNT), 0);
    chk("clr_q1", 32'(if1.Q), 0);

    // Registered-read latency.
    cyc(1'b1, 1'b0, 8'h5A, 1'b0);
    chk("lat_q0", 32'(if0.Q), 8'h5A);
    chk("lat_q1_pre", 32'(if1.Q), 0);
    cyc(1'b0, 1'b1, 8'h00, 1'b0);
    chk("lat_q1", 32'(if1.Q), 8'h5A);
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    chk("lat_hold", 32'(if1.Q), 8'h5A);

    // Wrap-around at constant occupancy.
    cyc(1'b1, 1'b0, 8'hE0, 1'b0);
    for (int i = 0; i < 20; i++) cyc(1'b1, 1'b1, W'($urandom), 1'b0);
    chk("wrap_count", 32'(if0.COUNT), 1);

    // Random traffic with varying bias so both boundaries get exercised.
    for (int seg = 0; seg < 12; seg++) begin
      int pw;
      int pr;
      pw = (seg % 3 == 0) ? 80 : (seg % 3 == 1) ? 50 : 20;
      pr = 100 - pw;
      for (int i = 0; i < 150; i++) begin
        cyc(($urandom_range(99) < pw), ($urandom_range(99) < pr), W'($urandom),
            ($urandom_range(199) == 0));
      end
    end

    // Asynchronous reset with five words stored.
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, W'(8'h40 + i), 1'b0);
    chk("pre_rst_count", 32'(if0.COUNT), 5);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_count", 32'(if0.COUNT), 0);
    chk("arst_empty", 32'(if0.EMPTY), 1);
    chk("arst_q0", 32'(if0.Q), 0);
    chk("arst_q1", 32'(if1.Q), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b1, 1'b0, 8'hC3, 1'b0);
    chk("post_count", 32'(if0.COUNT), 1);
    chk("post_q0", 32'(if0.Q), 8'hC3);
    cyc(1'b0, 1'b0, 8'h00, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
